mux_scheduler: RTL
==================

MUX_SCHEDULER -- requirements
Module: mux_scheduler

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 a_valid / a_data  input  1 / 8  source A offers byte.
REQ-004 a_ready  output  1  source A byte accepted when a_valid && a_ready at a clk edge.
REQ-005 b_valid, b_data, b_ready  and  g_valid, g_data, g_ready  SHALL behave identically to REQ-003 and REQ-004 for sources B and G.
REQ-006 sel  output  2  select to the downstream mux: 0 = alpha, 1 = beta, 2 = gamma.
REQ-007 cs  output  1  chip select to the downstream mux.
REQ-008 alpha / beta / gamma  output  8 each  holding-register contents for A / B / G, wired to the mux data inputs.
REQ-009 out_valid  output  1  the mux output holds a granted byte.
REQ-010 out_ready  input  1  the consumer takes the byte when out_valid && out_ready at a clk edge.
REQ-011 count  output  8  number of bytes delivered, modulo 256.

Function
REQ-012 Each source SHALL have a one-entry holding register (alpha/beta/gamma) and a full flag.
- x_ready = !full_x, decoded from registered state only.
REQ-013 On a capture (valid && ready):
- the register loads the data;
- full_x sets at the same edge.
REQ-014 The holding register SHALL hold its value until the next capture; it is not cleared on drain.
REQ-015 FSM states: IDLE and GRANT.
REQ-016 IDLE, no full flag set: stay in IDLE with cs=0, out_valid=0.
REQ-017 IDLE, at least one full flag set: at the next edge
- choose a winner by round robin;
- set sel to the winner;
- set cs=1 and out_valid=1;
- enter GRANT.
REQ-018 Round robin: search starts at index (last+1) mod 3 and proceeds upward mod 3; last holds the most recently delivered index.
REQ-019 GRANT with out_ready=0: sel, cs, out_valid and the granted register SHALL hold stable.
REQ-020 GRANT with out_ready=1, at that edge:
- clear full of the granted source;
- set last to sel;
- increment count;
- set cs=0 and out_valid=0;
- return to IDLE.
REQ-021 Latency: a byte captured at edge N is granted at the earliest at edge N+1 (cs high after N+1). Peak throughput is one byte per 2 cycles (one IDLE gap between grants).
REQ-022 A source whose byte is being drained SHALL have ready=0 in that cycle; its next capture is possible from the following cycle.
REQ-023 Captures on non-granted sources proceed during GRANT; they do not disturb sel, cs or out_valid.
REQ-024 count wraps from 255 to 0 without a flag.
REQ-025 sel is never 3; sel holds its last value while cs=0.

Reset
REQ-026 While reset is high, asynchronously:
- state=IDLE;
- all full flags=0 (all x_ready=1);
- alpha/beta/gamma=0;
- sel=0, cs=0, out_valid=0;
- last=2, so A has first priority after reset;
- count=0.
REQ-027 Reset asserted during GRANT drops the granted byte and all pending bytes; no delivery is counted.
REQ-028 The first grant is possible at the second rising edge after reset deasserts.

Verification
REQ-029 After reset, a_valid=1 with a_data=8'h11 for one cycle and out_ready=1 -> cs=1, sel=0, alpha=8'h11, out_valid=1 one edge after capture; count=1 after the next edge.
REQ-030 A=8'hA1, B=8'hB2, G=8'hC3 captured on the same edge, out_ready=1 -> delivered order sel 0,1,2 with values A1, B2, C3, one cycle of cs=0 between grants, count=3.
REQ-031 Grant to B held with out_ready=0 for 5 cycles while G captures 8'h77 -> sel=1, cs=1 and beta stay stable; g_ready drops to 0; G is delivered after B.
REQ-032 last=0 with A and B both full -> B wins; after B is delivered, A wins next.
REQ-033 Deliver 256 bytes -> count returns to 0.
REQ-034 Reset pulsed mid-GRANT -> cs=0, out_valid=0 and all x_ready=1 immediately (asynchronously); no byte delivered.

Source files
------------

// File: rtl/mux_scheduler.sv
// ---------------------------------------------------------------------------
// mux_scheduler
//
// Purpose:
//   Three byte sources (A, B, G) each feed a one-entry holding register.
//   A two-state scheduler (IDLE / GRANT) picks one full register by round
//   robin, drives the downstream mux select and chip select, and waits for
//   the consumer to take the byte. Delivered bytes are counted modulo 256.
//
// Handshake rule (all valid/ready pairs in this block):
//   A transfer happens at a rising clk edge exactly when valid && ready are
//   both high. The producer holds valid/data stable until the transfer;
//   ready is a function of registered state only and never depends on the
//   same-cycle valid.
//
// Ports:
//   i_clk                 clock, rising-edge active
//   i_reset               asynchronous active-high reset
//   i_a_valid/i_a_data    source A offer;  o_a_ready  = A register empty
//   i_b_valid/i_b_data    source B offer;  o_b_ready  = B register empty
//   i_g_valid/i_g_data    source G offer;  o_g_ready  = G register empty
//   o_sel                 mux select: 0 = alpha, 1 = beta, 2 = gamma
//   o_cs                  mux chip select (high while a byte is granted)
//   o_alpha/o_beta/o_gamma holding-register contents, wired to the mux
//   o_out_valid           mux output holds a granted byte
//   i_out_ready           consumer takes the byte when o_out_valid is high
//   o_count               bytes delivered, modulo 256
//   o_dbg_state           scheduler state (0 = IDLE, 1 = GRANT)
// ---------------------------------------------------------------------------
module mux_scheduler (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_a_valid,
   input  logic [7:0] i_a_data,
   output logic       o_a_ready,
   input  logic       i_b_valid,
   input  logic [7:0] i_b_data,
   output logic       o_b_ready,
   input  logic       i_g_valid,
   input  logic [7:0] i_g_data,
   output logic       o_g_ready,
   output logic [1:0] o_sel,
   output logic       o_cs,
   output logic [7:0] o_alpha,
   output logic [7:0] o_beta,
   output logic [7:0] o_gamma,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic [7:0] o_count,
   output logic       o_dbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   // Bit 0 = A, bit 1 = B, bit 2 = G throughout.
   logic [2:0] r_full;
   logic [7:0] r_alpha;
   logic [7:0] r_beta;
   logic [7:0] r_gamma;
   logic [1:0] r_sel;
   logic [1:0] r_last;
   logic [7:0] r_count;

   logic [2:0] w_cap;
   logic [2:0] w_drain_vec;
   logic [1:0] w_winner;
   logic       w_any_full;
   logic       w_grant_start;
   logic       w_drain;

   // ------------------------------------------------------------------
   // Capture side: a register accepts only while empty. A register being
   // drained is still full in that cycle, so it cannot capture until the
   // following cycle.
   // ------------------------------------------------------------------
   assign w_cap[0] = i_a_valid & ~r_full[0];
   assign w_cap[1] = i_b_valid & ~r_full[1];
   assign w_cap[2] = i_g_valid & ~r_full[2];

   assign w_any_full = |r_full;

   // ------------------------------------------------------------------
   // Round robin: search starts one past the last delivered index and
   // wraps upward modulo 3. Only consulted when at least one flag is set,
   // so the final fallback of each branch is the remaining full source.
   // ------------------------------------------------------------------
   always_comb begin
      w_winner = 2'd0;
      case (r_last)
         2'd0: begin
            if (r_full[1])      w_winner = 2'd1;
            else if (r_full[2]) w_winner = 2'd2;
            else                w_winner = 2'd0;
         end
         2'd1: begin
            if (r_full[2])      w_winner = 2'd2;
            else if (r_full[0]) w_winner = 2'd0;
            else                w_winner = 2'd1;
         end
         default: begin
            if (r_full[0])      w_winner = 2'd0;
            else if (r_full[1]) w_winner = 2'd1;
            else                w_winner = 2'd2;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Scheduler FSM: next state and one-cycle strobes.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_start = 1'b0;
      w_drain       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_full) begin
               w_state_nxt   = S_GRANT;
               w_grant_start = 1'b1;
            end
         end
         S_GRANT: begin
            if (i_out_ready) begin
               w_state_nxt = S_IDLE;
               w_drain     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // One-hot of the source being emptied at this edge (sel is never 3).
   assign w_drain_vec = w_drain ? (3'b001 << r_sel) : 3'b000;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Full flags: a drained source and a capturing source are always
   // different, so clear-then-set ordering is safe.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_full <= 3'b000;
      end else begin
         r_full <= (r_full & ~w_drain_vec) | w_cap;
      end
   end

   // Holding registers keep their value after drain; only a capture
   // overwrites them.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alpha <= 8'h00;
         r_beta  <= 8'h00;
         r_gamma <= 8'h00;
      end else begin
         if (w_cap[0]) r_alpha <= i_a_data;
         if (w_cap[1]) r_beta  <= i_b_data;
         if (w_cap[2]) r_gamma <= i_g_data;
      end
   end

   // Select updates only when a new grant starts, so it holds through
   // GRANT and keeps its last value while IDLE.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sel <= 2'd0;
      end else if (w_grant_start) begin
         r_sel <= w_winner;
      end
   end

   // last resets to 2 so that A is searched first after reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_last  <= 2'd2;
         r_count <= 8'h00;
      end else if (w_drain) begin
         r_last  <= r_sel;
         r_count <= r_count + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all decoded from registered state.
   // ------------------------------------------------------------------
   assign o_a_ready   = ~r_full[0];
   assign o_b_ready   = ~r_full[1];
   assign o_g_ready   = ~r_full[2];
   assign o_sel       = r_sel;
   assign o_cs        = (r_state == S_GRANT);
   assign o_out_valid = (r_state == S_GRANT);
   assign o_alpha     = r_alpha;
   assign o_beta      = r_beta;
   assign o_gamma     = r_gamma;
   assign o_count     = r_count;
   assign o_dbg_state = r_state;

endmodule
